serializer_arbiter: RTL and testbench

Round-robin scheduler sharing one `serializer` instance between `N_REQ` requesters. It accepts one word per grant, captures it, and launches it into the serializer with a single-cycle `data_val_i` pulse. It then holds off further launches until the serializer's `busy_o` drops. Words whose length lies in the serializer's ignore window are acknowledged and discarded without a launch.

---
 rtl/serializer_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_serializer_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_arbiter.sv
// serializer_arbiter: round-robin scheduler that shares one serializer
// between N_REQ requesters. One word is accepted per grant. Words whose
// length falls in the serializer ignore window are acked and dropped.
// Every other word is captured, launched with a one-cycle ser_val_o pulse,
// and followed by a done pulse once the serializer is idle again.

// Per-requester slice: decodes the requester's one-hot strobes and masks
// its word onto the shared AND-OR capture mux.
module serializer_arbiter_lane #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = 4,
    parameter int PTR_W  = 2,
    parameter int IDX    = 0
) (
    input  logic [PTR_W-1:0]  winner,
    input  logic [PTR_W-1:0]  owner,
    input  logic              grant_en,
    input  logic              drop_en,
    input  logic              done_en,
    input  logic [DATA_W-1:0] data,
    input  logic [MOD_W-1:0]  mod,
    output logic              ack,
    output logic              drop,
    output logic              done,
    output logic [DATA_W-1:0] data_sel,
    output logic [MOD_W-1:0]  mod_sel
);
    logic is_win;
    logic is_own;

    assign is_win   = (winner == PTR_W'(IDX));
    assign is_own   = (owner == PTR_W'(IDX));
    assign ack      = grant_en & is_win;
    assign drop     = drop_en & is_win;
    assign done     = done_en & is_own;
    assign data_sel = is_win ? data : '0;
    assign mod_sel  = is_win ? mod : '0;
endmodule

module serializer_arbiter #(
    parameter int N_REQ         = 4,
    parameter int DATA_W        = 16,
    parameter int MOD_W         = $clog2(DATA_W),
    parameter int MOD_IGNORE_LO = 1,
    parameter int MOD_IGNORE_HI = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    input  logic [N_REQ*MOD_W-1:0]    req_mod_i,
    input  logic [N_REQ-1:0]          req_val_i,
    output logic [N_REQ-1:0]          req_ack_o,
    output logic [N_REQ-1:0]          done_o,
    output logic [N_REQ-1:0]          drop_o,
    output logic [DATA_W-1:0]         ser_data_o,
    output logic [MOD_W-1:0]          ser_mod_o,
    output logic                      ser_val_o,
    input  logic                      ser_busy_i,
    output logic [$clog2(N_REQ)-1:0]  owner_o,
    output logic                      busy_o
);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    state_t                          state;
    logic [PTR_W-1:0]                rr_ptr;
    logic [PTR_W-1:0]                winner;
    logic [PTR_W-1:0]                nxt_ptr;
    logic [2*N_REQ-1:0]              req_dbl;
    logic [N_REQ-1:0]                req_rot;
    logic                            grant_en;
    logic                            drop_en;
    logic                            done_en;
    logic                            in_window;
    logic [N_REQ-1:0][DATA_W-1:0]    lane_data;
    logic [N_REQ-1:0][MOD_W-1:0]     lane_mod;
    logic [DATA_W-1:0]               sel_data;
    logic [MOD_W-1:0]                sel_mod;

    // Rotate requests so bit 0 is the requester at rr_ptr.
    assign req_dbl = {req_val_i, req_val_i} >> rr_ptr;
    assign req_rot = req_dbl[N_REQ-1:0];

    // Pick the first requester at or above rr_ptr, with wrap, and the pointer after it.
    always_comb begin
        int off;
        int w;
        int n;
        off = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) off = i;
        end
        w = int'(rr_ptr) + off;
        if (w >= N_REQ) w = w - N_REQ;
        n = w + 1;
        if (n >= N_REQ) n = 0;
        winner  = PTR_W'(w);
        nxt_ptr = PTR_W'(n);
    end

    // Strobes are gated by reset so nothing leaks out while rst_i is held.
    assign grant_en  = !rst_i && (state == IDLE) && !ser_busy_i && (|req_val_i);
    assign in_window = (sel_mod >= MOD_W'(MOD_IGNORE_LO)) && (sel_mod <= MOD_W'(MOD_IGNORE_HI));
    assign drop_en   = grant_en && in_window;
    assign done_en   = !rst_i && (state == WAIT) && !ser_busy_i;

    genvar k;
    generate
        for (k = 0; k < N_REQ; k++) begin : g_lane
            serializer_arbiter_lane #(
                .DATA_W (DATA_W),
                .MOD_W  (MOD_W),
                .PTR_W  (PTR_W),
                .IDX    (k)
            ) u_lane (
                .winner   (winner),
                .owner    (owner_o),
                .grant_en (grant_en),
                .drop_en  (drop_en),
                .done_en  (done_en),
                .data     (req_data_i[k*DATA_W +: DATA_W]),
                .mod      (req_mod_i[k*MOD_W +: MOD_W]),
                .ack      (req_ack_o[k]),
                .drop     (drop_o[k]),
                .done     (done_o[k]),
                .data_sel (lane_data[k]),
                .mod_sel  (lane_mod[k])
            );
        end
    endgenerate

    // OR the masked lane words together; only the winner's lane is non-zero.
    always_comb begin
        sel_data = '0;
        sel_mod  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_data = sel_data | lane_data[i];
            sel_mod  = sel_mod | lane_mod[i];
        end
    end

    // Control FSM with registered serializer-side outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner_o    <= '0;
            ser_data_o <= '0;
            ser_mod_o  <= '0;
            ser_val_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ser_val_o <= 1'b0;
                    if (grant_en) begin
                        rr_ptr <= nxt_ptr;
                        if (!in_window) begin
                            ser_data_o <= sel_data;
                            ser_mod_o  <= sel_mod;
                            owner_o    <= winner;
                            ser_val_o  <= 1'b1;
                            busy_o     <= 1'b1;
                            state      <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    ser_val_o <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (!ser_busy_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    ser_val_o <= 1'b0;
                    busy_o    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed bench for serializer_arbiter with a small serializer busy model.
module tb_serializer_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*DW-1:0] req_data;
    logic [N*MW-1:0] req_mod;
    logic [N-1:0]  req_val;
    logic [N-1:0]  req_ack;
    logic [N-1:0]  done;
    logic [N-1:0]  drop;
    logic [DW-1:0] ser_data;
    logic [MW-1:0] ser_mod;
    logic          ser_val;
    logic          ser_busy;
    logic [1:0]    owner;
    logic          busy;

    logic [5:0]    cnt = '0;
    logic          force_busy;
    logic          watch3;
    logic          saw3 = 1'b0;
    int            checks = 0;
    int            errors = 0;

    serializer_arbiter #(
        .N_REQ(N), .DATA_W(DW), .MOD_W(MW), .MOD_IGNORE_LO(1), .MOD_IGNORE_HI(2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_data_i (req_data),
        .req_mod_i  (req_mod),
        .req_val_i  (req_val),
        .req_ack_o  (req_ack),
        .done_o     (done),
        .drop_o     (drop),
        .ser_data_o (ser_data),
        .ser_mod_o  (ser_mod),
        .ser_val_o  (ser_val),
        .ser_busy_i (ser_busy),
        .owner_o    (owner),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Serializer model: busy for mod cycles (16 for mod 0) starting the cycle
    // after the launch pulse. Deliberately not reset by rst.
    always @(posedge clk) begin
        if (ser_val) cnt <= (ser_mod == '0) ? 6'd16 : {2'b00, ser_mod};
        else if (cnt != '0) cnt <= cnt - 6'd1;
    end
    assign ser_busy = (cnt != '0) || force_busy;

    always @(negedge clk) if (watch3 && req_ack[3]) saw3 <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output logic [N-1:0] a, output int n);
        n = 0;
        a = '0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n++;
            if (req_ack != '0) begin
                a = req_ack;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 60; i++) begin
            if (!busy) break;
            cyc();
        end
        chk("idle_timeout", 32'(i < 60), 32'd1);
    endtask

    initial begin
        logic [N-1:0] a;
        int n;
        logic sawdone;
        rst = 1'b1;
        req_data = '0;
        req_mod = '0;
        req_val = 4'b0001;
        force_busy = 1'b0;
        watch3 = 1'b0;
        #2;
        chk("rst_ack", req_ack, 4'b0000);
        chk("rst_val", ser_val, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 2'd0);
        chk("rst_data", ser_data, 16'h0000);
        cyc();
        cyc();
        rst = 1'b0;
        req_val = '0;
        cyc();

        // Round robin, all four holding, mod 3 each
        for (int k = 0; k < N; k++) begin
            req_data[k*DW +: DW] = 16'hC000 | 16'(k);
            req_mod[k*MW +: MW]  = 4'd3;
        end
        req_val = 4'b1111;
        #1;
        chk("rr_ack0", req_ack, 4'b0001);
        cyc();
        chk("rr_launch_val", ser_val, 1'b1);
        chk("rr_launch_data", ser_data, 16'hC000);
        chk("rr_launch_owner", owner, 2'd0);
        wait_ack(a, n);
        chk("rr_ack1", a, 4'b0010);
        chk("rr_spacing", n, 5);
        cyc();
        wait_ack(a, n);
        chk("rr_ack2", a, 4'b0100);
        cyc();
        wait_ack(a, n);
        chk("rr_ack3", a, 4'b1000);
        cyc();
        wait_ack(a, n);
        chk("rr_ack_wrap0", a, 4'b0001);
        cyc();
        req_val = '0;
        wait_idle();

        // Ignore window on requester 1 (rr_ptr = 1)
        req_mod[1*MW +: MW] = 4'd1;
        req_val = 4'b0010;
        #1;
        chk("drop1_ack", req_ack, 4'b0010);
        chk("drop1_drop", drop, 4'b0010);
        cyc();
        chk("drop1_noval", ser_val, 1'b0);
        chk("drop1_nobusy", busy, 1'b0);
        req_mod[1*MW +: MW] = 4'd2;
        #1;
        chk("drop2_ack", req_ack, 4'b0010);
        chk("drop2_drop", drop, 4'b0010);
        cyc();
        req_val = '0;
        chk("drop2_noval", ser_val, 1'b0);
        req_mod[0*MW +: MW] = 4'd3;
        req_mod[1*MW +: MW] = 4'd3;
        req_mod[3*MW +: MW] = 4'd3;
        req_val = 4'b1011;
        #1;
        chk("ptr2_ack", req_ack, 4'b1000);
        chk("ptr2_nodrop", drop, 4'b0000);
        cyc();
        req_val = '0;
        #1;
        chk("ptr2_val", ser_val, 1'b1);
        chk("ptr2_owner", owner, 2'd3);
        chk("ptr2_mod", ser_mod, 4'd3);
        wait_idle();

        // Full length word (mod 0), rr_ptr = 0
        req_data[0*DW +: DW] = 16'h8001;
        req_mod[0*MW +: MW] = 4'd0;
        req_val = 4'b0001;
        #1;
        chk("full_ack", req_ack, 4'b0001);
        chk("full_nodrop", drop, 4'b0000);
        cyc();
        req_val = '0;
        #1;
        chk("full_val", ser_val, 1'b1);
        chk("full_data", ser_data, 16'h8001);
        chk("full_mod", ser_mod, 4'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done != '0) break;
            n++;
        end
        chk("full_busy_cycles", n, 16);
        chk("full_done", done, 4'b0001);
        cyc();
        chk("full_idle", busy, 1'b0);
        chk("full_done_clear", done, 4'b0000);

        // External busy blocks grants (rr_ptr = 1)
        force_busy = 1'b1;
        req_mod[2*MW +: MW] = 4'd4;
        req_data[2*DW +: DW] = 16'hA5C3;
        req_val = 4'b0100;
        #1;
        chk("ext_block0", req_ack, 4'b0000);
        cyc();
        cyc();
        chk("ext_block2", req_ack, 4'b0000);
        force_busy = 1'b0;
        #1;
        chk("ext_release_ack", req_ack, 4'b0100);
        cyc();
        req_val = '0;
        #1;
        chk("single_val", ser_val, 1'b1);
        chk("single_data", ser_data, 16'hA5C3);
        chk("single_mod", ser_mod, 4'd4);
        chk("single_owner", owner, 2'd2);
        cyc();
        cyc();
        cyc();
        cyc();
        chk("single_nodone", done, 4'b0000);
        cyc();
        chk("single_done", done, 4'b0100);
        cyc();
        chk("single_idle", busy, 1'b0);

        // Withdrawn request: rr_ptr = 3, requester 3 leaves before grant
        watch3 = 1'b1;
        force_busy = 1'b1;
        req_mod[3*MW +: MW] = 4'd4;
        req_mod[0*MW +: MW] = 4'd4;
        req_val = 4'b1001;
        cyc();
        chk("wd_blocked", req_ack, 4'b0000);
        req_val = 4'b0001;
        force_busy = 1'b0;
        #1;
        chk("wd_ack0", req_ack, 4'b0001);
        cyc();
        req_val = '0;
        wait_idle();
        chk("wd_never3", saw3, 1'b0);
        watch3 = 1'b0;

        // Reset mid-WAIT (rr_ptr = 1), long word on requester 1
        req_mod[1*MW +: MW] = 4'd15;
        req_val = 4'b0010;
        #1;
        chk("mid_ack", req_ack, 4'b0010);
        cyc();
        req_val = '0;
        cyc();
        cyc();
        rst = 1'b1;
        req_val = 4'b0101;
        #1;
        chk("mid_rst_val", ser_val, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_owner", owner, 2'd0);
        chk("mid_rst_data", ser_data, 16'h0000);
        chk("mid_rst_mod", ser_mod, 4'd0);
        chk("mid_rst_ack", req_ack, 4'b0000);
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_serbusy", ser_busy, 1'b1);
        chk("post_rst_noack", req_ack, 4'b0000);
        sawdone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!ser_busy) break;
            if (req_ack != '0 || done != '0) sawdone = 1'b1;
            cyc();
        end
        chk("post_rst_quiet", sawdone, 1'b0);
        chk("post_rst_ack0", req_ack, 4'b0001);
        cyc();
        req_val = '0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
